// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES decryption round datapath: sizes, FSM encodings
// and the column-major byte placement helper.
package aes_dec_pkg;

    localparam int unsigned AES_NB_BYTES = 16;
    localparam int unsigned AES_BLK_W    = 128;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Byte index j = 4*col + row, so col occupies the upper bits.
    typedef struct packed {
        logic [1:0] col;
        logic [1:0] row;
    } byte_pos_t;

    // MSB position of byte (r,c) inside a 128-bit block.
    function automatic logic [6:0] byte_msb(input logic [1:0] r, input logic [1:0] c);
        return 7'(int'(AES_BLK_W) - 1 - 8 * (4 * int'(c) + int'(r)));
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box (FIPS-197 table).
module aes_inv_sbox (
    input  logic [7:0] val,
    output logic [7:0] inv_val
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign inv_val = INV_SBOX[val];

endmodule

// File: rtl/aes_inv_sub_shift_addkey.sv
// AES-128 decryption round front-end: InvShiftRows -> InvSubBytes -> AddRoundKey,
// computed LANES bytes per cycle over a set of shared inverse S-boxes.
module aes_inv_sub_shift_addkey
    import aes_dec_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int unsigned STEPS  = AES_NB_BYTES / LANES;
    localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("aes_inv_sub_shift_addkey: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic              out_valid_d;
    logic              load;
    logic              write;
    logic [127:0]      st_q;
    logic [127:0]      key_q;

    byte_pos_t   lane_pos [LANES];
    logic [7:0]  sbox_in  [LANES];
    logic [7:0]  sbox_out [LANES];
    logic [7:0]  key_byte [LANES];
    logic [7:0]  lane_res [LANES];

    assign in_ready = (state_q == ST_IDLE) && !rst;

    // Next-state, step counter and control strobes.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        out_valid_d = out_valid;
        load        = 1'b0;
        write       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = ST_BUSY;
                    step_d  = '0;
                    load    = 1'b1;
                end
            end
            ST_BUSY: begin
                write = 1'b1;
                if (step_q == LAST_STEP) begin
                    step_d      = '0;
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                step_d      = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Each lane owns output byte LANES*step+l; its source byte sits `row` columns to the left.
    always_comb begin
        for (int l = 0; l < int'(LANES); l++) begin
            lane_pos[l] = byte_pos_t'(4'(int'(LANES) * int'(step_q) + l));
            sbox_in[l]  = st_q[byte_msb(lane_pos[l].row, 2'(lane_pos[l].col - lane_pos[l].row)) -: 8];
            key_byte[l] = key_q[byte_msb(lane_pos[l].row, lane_pos[l].col) -: 8];
        end
    end

    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        aes_inv_sbox u_inv_sbox (
            .val     (sbox_in[g]),
            .inv_val (sbox_out[g])
        );
        assign lane_res[g] = sbox_out[g] ^ key_byte[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            out_valid <= out_valid_d;
        end
    end

    // Latched operands and output bytes; unwritten bytes keep the previous block's values.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q     <= '0;
            key_q    <= '0;
            out_data <= '0;
        end else begin
            if (load) begin
                st_q  <= in_data;
                key_q <= round_key;
            end
            if (write) begin
                for (int l = 0; l < int'(LANES); l++) begin
                    out_data[byte_msb(lane_pos[l].row, lane_pos[l].col) -: 8] <= lane_res[l];
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_inv_sub_shift_addkey.sv
// Self-checking bench for aes_inv_sub_shift_addkey: directed AES vectors, backpressure,
// mid-block reset, random blocks and a LANES sweep against a GF(2^8)-derived model.
module tb_aes_inv_sub_shift_addkey;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data = '0;
    logic [127:0] round_key = '0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_data;

    logic         s_in_valid = 1'b0;
    logic         s_out_ready = 1'b0;
    logic [127:0] s_in_data = '0;
    logic [127:0] s_round_key = '0;
    logic         s1_in_ready, s2_in_ready, s16_in_ready;
    logic         s1_out_valid, s2_out_valid, s16_out_valid;
    logic [127:0] s1_out_data, s2_out_data, s16_out_data;

    int tests = 0;
    int fails = 0;
    logic [7:0]   inv_tbl [256];
    logic [127:0] last_out;

    aes_inv_sub_shift_addkey #(.LANES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .round_key(round_key), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );
    aes_inv_sub_shift_addkey #(.LANES(1)) dut_l1 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s1_in_ready), .in_data(s_in_data),
        .round_key(s_round_key), .out_valid(s1_out_valid), .out_ready(s_out_ready), .out_data(s1_out_data)
    );
    aes_inv_sub_shift_addkey #(.LANES(2)) dut_l2 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s2_in_ready), .in_data(s_in_data),
        .round_key(s_round_key), .out_valid(s2_out_valid), .out_ready(s_out_ready), .out_data(s2_out_data)
    );
    aes_inv_sub_shift_addkey #(.LANES(16)) dut_l16 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s16_in_ready), .in_data(s_in_data),
        .round_key(s_round_key), .out_valid(s16_out_valid), .out_ready(s_out_ready), .out_data(s16_out_data)
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // Forward S-box from field inverse + affine map, then inverted into a lookup table.
    task automatic build_inv_tbl();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, s, xb;
            xb = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            inv_tbl[s] = xb;
        end
    endtask

    function automatic logic [7:0] get_b(input logic [127:0] v, input int r, input int c);
        return v[127 - 8 * (4 * c + r) -: 8];
    endfunction

    function automatic logic [127:0] ref_out(input logic [127:0] d, input logic [127:0] k);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8 * (4 * c + r) -: 8] = inv_tbl[get_b(d, r, (c - r + 4) % 4)] ^ get_b(k, r, c);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] v);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = get_b(v, 0, c); a1 = get_b(v, 1, c); a2 = get_b(v, 2, c); a3 = get_b(v, 3, c);
            o[127 - 8 * (4 * c + 0) -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[127 - 8 * (4 * c + 1) -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[127 - 8 * (4 * c + 2) -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[127 - 8 * (4 * c + 3) -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    // ---------------- checking / driving ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic start_blk(input logic [127:0] d, input logic [127:0] k);
        int n;
        in_valid = 1'b1; in_data = d; round_key = k;
        n = 0;
        while (!in_ready && n < 60) begin @(negedge clk); n++; end
        if (!in_ready) chk("accept_timeout", 128'(in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Returns the accept-relative edge at which out_valid is first sampled high.
    task automatic wait_out(output int lat);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin @(negedge clk); n++; end
        if (!out_valid) chk("out_valid_timeout", 128'(out_valid), 128'(1));
        lat = n + 1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_out_valid", 128'(out_valid), 128'(0));
        chk("post_hs_in_ready", 128'(in_ready), 128'(1));
    endtask

    task automatic run_blk(input string tag, input logic [127:0] d, input logic [127:0] k);
        int lat;
        start_blk(d, k);
        wait_out(lat);
        chk({tag, "_lat"}, 128'(lat), 128'(5));
        chk(tag, out_data, ref_out(d, k));
        last_out = out_data;
        consume();
    endtask

    localparam logic [127:0] FIPS_IN  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] FIPS_KEY = 128'h549932d1f08557681093ed9cbe2c974e;
    localparam logic [127:0] FIPS_OUT = 128'he9f74eec023020f61bf2ccf2353c21c7;
    localparam logic [127:0] FIPS_IMC = 128'h54d990a16ba09ab596bbf40ea111702f;
    localparam logic [127:0] KEY_SEQ  = 128'h0f0e0d0c0b0a09080706050403020100;

    initial begin : timeout_guard
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] a_d, a_k, b_d, b_k, snap;
        int lat, l1, l2, l16, n;

        build_inv_tbl();
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 128'(in_ready), 128'(0));
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_out_data", out_data, 128'(0));
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);

        run_blk("zero_vec", 128'(0), 128'(0));
        chk("zero_vec_const", last_out, {16{8'h52}});
        run_blk("ident_key0", {16{8'h63}}, 128'(0));
        chk("ident_key0_const", last_out, 128'(0));
        run_blk("ident_keyseq", {16{8'h63}}, KEY_SEQ);
        chk("ident_keyseq_const", last_out, KEY_SEQ);
        run_blk("fips_r1", FIPS_IN, FIPS_KEY);
        chk("fips_r1_const", last_out, FIPS_OUT);
        chk("fips_r1_imc", inv_mix(last_out), FIPS_IMC);
        repeat (3) @(negedge clk);
        chk("idle_hold", out_data, FIPS_OUT);

        // Backpressure in DONE with an ignored input pulse.
        a_d = {$urandom, $urandom, $urandom, $urandom};
        a_k = {$urandom, $urandom, $urandom, $urandom};
        b_d = {$urandom, $urandom, $urandom, $urandom};
        b_k = {$urandom, $urandom, $urandom, $urandom};
        start_blk(a_d, a_k);
        wait_out(lat);
        chk("bp_lat", 128'(lat), 128'(5));
        chk("bp_data", out_data, ref_out(a_d, a_k));
        snap = out_data;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                in_valid = 1'b1;
                in_data = {$urandom, $urandom, $urandom, $urandom};
                round_key = {$urandom, $urandom, $urandom, $urandom};
            end
            if (i == 6) in_valid = 1'b0;
            @(negedge clk);
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            chk("bp_out_data", out_data, snap);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        // in_valid together with out_ready: only the output handshake happens.
        in_valid = 1'b1; in_data = b_d; round_key = b_k; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("simul_out_valid", 128'(out_valid), 128'(0));
        chk("simul_in_ready", 128'(in_ready), 128'(1));
        start_blk(b_d, b_k);
        wait_out(lat);
        chk("after_bp_lat", 128'(lat), 128'(5));
        chk("after_bp_data", out_data, ref_out(b_d, b_k));
        consume();

        // Reset while BUSY at step 2.
        start_blk(a_d ^ b_d, a_k ^ b_k);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_out_data", out_data, 128'(0));
        chk("midrst_in_ready", 128'(in_ready), 128'(0));
        rst = 1'b0;
        #1;
        chk("midrst_idle_ready", 128'(in_ready), 128'(1));
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || out_data !== 128'(0)) n++;
        end
        chk("midrst_no_spurious", 128'(n), 128'(0));
        run_blk("midrst_next", b_d, a_k);

        // Random blocks with random idle gaps.
        for (int i = 0; i < 6; i++) begin
            run_blk("rand_blk", {$urandom, $urandom, $urandom, $urandom},
                    {$urandom, $urandom, $urandom, $urandom});
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // LANES sweep on the FIPS vector.
        s_in_valid = 1'b1; s_in_data = FIPS_IN; s_round_key = FIPS_KEY;
        chk("sweep_ready", 128'({s1_in_ready, s2_in_ready, s16_in_ready}), 128'(3'b111));
        @(posedge clk);
        @(negedge clk);
        s_in_valid = 1'b0;
        l1 = -1; l2 = -1; l16 = -1;
        n = 0;
        while (n < 40 && (l1 < 0 || l2 < 0 || l16 < 0)) begin
            if (s1_out_valid && l1 < 0) l1 = n + 1;
            if (s2_out_valid && l2 < 0) l2 = n + 1;
            if (s16_out_valid && l16 < 0) l16 = n + 1;
            @(negedge clk);
            n++;
        end
        chk("sweep_l1_lat", 128'(l1), 128'(17));
        chk("sweep_l2_lat", 128'(l2), 128'(9));
        chk("sweep_l16_lat", 128'(l16), 128'(2));
        chk("sweep_l1_data", s1_out_data, ref_out(FIPS_IN, FIPS_KEY));
        chk("sweep_l2_data", s2_out_data, ref_out(FIPS_IN, FIPS_KEY));
        chk("sweep_l16_data", s16_out_data, ref_out(FIPS_IN, FIPS_KEY));
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        chk("sweep_release", 128'({s1_out_valid, s2_out_valid, s16_out_valid}), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
